// File: rtl/uart_pkg.sv
// Shared constants for the memory-mapped UART transmitter: bus addresses,
// FSM state encodings and STATUS register bit positions.
package uart_pkg;

    localparam logic [15:0] UART_DATA_ADDR   = 16'h8000;
    localparam logic [15:0] UART_STATUS_ADDR = 16'h8001;

    localparam logic [2:0] UART_IDLE   = 3'd0;
    localparam logic [2:0] UART_START  = 3'd1;
    localparam logic [2:0] UART_DATA   = 3'd2;
    localparam logic [2:0] UART_PARITY = 3'd3;
    localparam logic [2:0] UART_STOP   = 3'd4;

    localparam int STAT_FULL      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_ACTIVE    = 2;
    localparam int STAT_OVF       = 3;
    localparam int STAT_COUNT_LSB = 4;
    localparam int STAT_PARITY    = 8;

    function automatic logic evenParity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// Byte FIFO feeding the UART shifter; pointers carry one extra MSB so that
// full and empty can be told apart when the index bits match.
module tx_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int WIDTH      = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic                        pop,
    input  logic [WIDTH-1:0]            din,
    output logic [WIDTH-1:0]            dout,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] count
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]      wrPtr_q;
    logic [AW:0]      rdPtr_q;
    logic             doPush;
    logic             doPop;

    assign count = wrPtr_q - rdPtr_q;
    assign empty = (wrPtr_q == rdPtr_q);
    assign full  = (count == (AW+1)'(FIFO_DEPTH));
    assign dout  = mem_q[rdPtr_q[AW-1:0]];

    // A push into a full FIFO is still taken when a pop frees the slot on the same edge.
    assign doPush = push && (!full || pop);
    assign doPop  = pop && !empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + (AW+1)'(1);
            if (doPop)  rdPtr_q <= rdPtr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem_q[wrPtr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_tx_port.sv
// Memory-mapped UART transmitter: DATA writes queue bytes, STATUS reads report state.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1) and advertise it in STATUS.
module uart_tx_port
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] bus_addr,
    input  logic [15:0] bus_wdata,
    input  logic        bus_we,
    output logic [15:0] bus_rdata,
    output logic        tx,
    output logic        busy
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [2:0]    state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bitIdx_q, bitIdx_d;
    logic [7:0]    data_q, data_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   rdata_q, rdata_d;

    logic          fifoPop;
    logic          fifoFull;
    logic          fifoEmpty;
    logic [7:0]    fifoDout;
    logic [CW-1:0] fifoCount;
    logic          wrData;
    logic          wrStatus;
    logic          baudWrap;
    logic          active;
    logic          parityAdv;
    logic [15:0]   status;
    logic          unusedWdata;

    assign wrData      = bus_we && (bus_addr == UART_DATA_ADDR);
    assign wrStatus    = bus_we && (bus_addr == UART_STATUS_ADDR);
    assign baudWrap    = (baud_q == BW'(CLKS_PER_BIT - 1));
    assign active      = (state_q != UART_IDLE);
    assign busy        = !fifoEmpty || active;
    assign bus_rdata   = rdata_q;
    assign unusedWdata = ^bus_wdata[15:8];

`ifdef UART_TX_PARITY_EN
    assign parityAdv = 1'b1;
`else
    assign parityAdv = 1'b0;
`endif

    tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wrData),
        .pop   (fifoPop),
        .din   (bus_wdata[7:0]),
        .dout  (fifoDout),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .count (fifoCount)
    );

    // Bit-timing FSM; IDLE and the end of STOP both pop straight into START.
    always_comb begin
        state_d  = state_q;
        baud_d   = '0;
        bitIdx_d = bitIdx_q;
        data_d   = data_q;
        fifoPop  = 1'b0;
        if (active && !baudWrap) baud_d = baud_q + BW'(1);
        case (state_q)
            UART_IDLE: begin
                if (!fifoEmpty) begin
                    fifoPop = 1'b1;
                    data_d  = fifoDout;
                    state_d = UART_START;
                end
            end
            UART_START: begin
                if (baudWrap) begin
                    state_d  = UART_DATA;
                    bitIdx_d = 3'd0;
                end
            end
            UART_DATA: begin
                if (baudWrap) begin
                    if (bitIdx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = UART_PARITY;
`else
                        state_d = UART_STOP;
`endif
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            UART_PARITY: begin
                if (baudWrap) state_d = UART_STOP;
            end
`endif
            UART_STOP: begin
                if (baudWrap) begin
                    if (!fifoEmpty) begin
                        fifoPop = 1'b1;
                        data_d  = fifoDout;
                        state_d = UART_START;
                    end else begin
                        state_d = UART_IDLE;
                    end
                end
            end
            default: state_d = UART_IDLE;
        endcase
    end

    always_comb begin
        case (state_q)
            UART_START:  tx = 1'b0;
            UART_DATA:   tx = data_q[bitIdx_q];
            UART_PARITY: tx = evenParity(data_q);
            default:     tx = 1'b1;
        endcase
    end

    // Status reflects pre-edge state, so a read sees the FIFO before that edge's push/pop.
    always_comb begin
        status                        = '0;
        status[STAT_FULL]             = fifoFull;
        status[STAT_EMPTY]            = fifoEmpty;
        status[STAT_ACTIVE]           = active;
        status[STAT_OVF]              = ovf_q;
        status[STAT_COUNT_LSB +: 4]   = 4'(fifoCount);
        status[STAT_PARITY]           = parityAdv;
        rdata_d = (bus_addr == UART_STATUS_ADDR) ? status : 16'h0000;
        ovf_d   = ovf_q;
        if (wrData && fifoFull && !fifoPop) ovf_d = 1'b1;
        if (wrStatus && bus_wdata[3])       ovf_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= UART_IDLE;
            baud_q   <= '0;
            bitIdx_q <= '0;
            data_q   <= '0;
            ovf_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bitIdx_q <= bitIdx_d;
            data_q   <= data_d;
            ovf_q    <= ovf_d;
            rdata_q  <= rdata_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_port.sv
// Self-checking bench for uart_tx_port: directed steps with random bytes,
// compared against a queue-based model of what the serial line should carry.
module tb_uart_tx_port;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam logic [15:0] DATA_ADDR   = 16'h8000;
    localparam logic [15:0] STATUS_ADDR = 16'h8001;
`ifdef UART_TX_PARITY_EN
    localparam int          NBITS = 11;
    localparam logic [15:0] PARW  = 16'h0100;
`else
    localparam int          NBITS = 10;
    localparam logic [15:0] PARW  = 16'h0000;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] bus_addr = '0;
    logic [15:0] bus_wdata = '0;
    logic        bus_we = 1'b0;
    logic [15:0] bus_rdata;
    logic        tx;
    logic        busy;

    int checkCount = 0;
    int passCount  = 0;

    logic [7:0] pending[$];
    logic [7:0] burst[$];
    logic       modelOvf = 1'b0;

    uart_tx_port #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_we    (bus_we),
        .bus_rdata (bus_rdata),
        .tx        (tx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    // Line level of bit slot idx within an 8N1 / 8E1 frame for byte b.
    function automatic logic frameBit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (NBITS == 11 && idx == 9) return ^b;
        return 1'b1;
    endfunction

    function automatic logic [15:0] statusWord(input int cnt, input logic ovf, input logic act);
        logic [15:0] w;
        w      = PARW;
        w[7:4] = 4'(cnt);
        w[3]   = ovf;
        w[2]   = act;
        w[1]   = (cnt == 0);
        w[0]   = (cnt == DEPTH);
        return w;
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] d);
        bus_addr  = a;
        bus_wdata = d;
        bus_we    = 1'b1;
        @(negedge clk);
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
    endtask

    // Bytes accepted while a frame is in flight may occupy DEPTH FIFO slots.
    task automatic modelPush(input logic [7:0] b, input int inFlight);
        if (pending.size() - inFlight < DEPTH) pending.push_back(b);
        else modelOvf = 1'b1;
    endtask

    task automatic checkFrame(input logic [7:0] b, input int start);
        for (int c = start; c < NBITS * CPB; c++) begin
            checkOutput($sformatf("tx_%02h_bit%0d", b, c / CPB), {15'b0, tx}, {15'b0, frameBit(b, c / CPB)});
            @(negedge clk);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_busy"}, {15'b0, busy}, 16'h0000);
        checkOutput({tag, "_tx"}, {15'b0, tx}, 16'h0001);
    endtask

    // Writes every byte of burst on consecutive edges, then checks all frames back to back.
    task automatic runBurst();
        int n;
        n = burst.size();
        for (int i = 0; i < n; i++) begin
            modelPush(burst[i], (i == 0) ? 0 : 1);
            applyStimulus(DATA_ADDR, {8'h00, burst[i]});
        end
        checkFrame(pending.pop_front(), n - 2);
        while (pending.size() > 0) checkFrame(pending.pop_front(), 0);
        checkIdle("burst_end");
    endtask

    initial begin
        int n;
        logic [7:0] b;

        #1;
        checkIdle("reset");
        checkOutput("reset_rdata", bus_rdata, 16'h0000);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bus_addr = STATUS_ADDR;
        @(negedge clk);
        checkOutput("status_after_reset", bus_rdata, statusWord(0, 1'b0, 1'b0));
        bus_addr = '0;

        $display("[TB] single byte A5 with status reads");
        modelPush(8'hA5, 0);
        applyStimulus(DATA_ADDR, 16'h00A5);
        bus_addr = STATUS_ADDR;
        @(negedge clk);
        checkOutput("status_count1", bus_rdata, statusWord(1, 1'b0, 1'b0));
        checkOutput("busy_in_frame", {15'b0, busy}, 16'h0001);
        checkOutput("start_bit_c0", {15'b0, tx}, 16'h0000);
        @(negedge clk);
        checkOutput("status_in_start", bus_rdata, statusWord(0, 1'b0, 1'b1));
        bus_addr = 16'h1234;
        checkFrame(pending.pop_front(), 1);
        checkIdle("a5_end");
        checkOutput("other_addr_read", bus_rdata, 16'h0000);
        bus_addr = DATA_ADDR;
        @(negedge clk);
        checkOutput("data_addr_read", bus_rdata, 16'h0000);
        bus_addr = '0;

        $display("[TB] back-to-back 00 FF");
        burst = {8'h00, 8'hFF};
        runBurst();

        $display("[TB] random burst");
        burst.delete();
        n = $urandom_range(2, 4);
        for (int i = 0; i < n; i++) burst.push_back(8'($urandom));
        runBurst();

        $display("[TB] overflow");
        burst.delete();
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            modelPush(b, (i == 0) ? 0 : 1);
            applyStimulus(DATA_ADDR, {8'h00, b});
        end
        bus_addr = STATUS_ADDR;
        @(negedge clk);
        checkOutput("status_full_ovf", bus_rdata, statusWord(pending.size() - 1, modelOvf, 1'b1));
        applyStimulus(STATUS_ADDR, 16'h0008);
        modelOvf = 1'b0;
        bus_addr = STATUS_ADDR;
        @(negedge clk);
        checkOutput("status_ovf_cleared", bus_rdata, statusWord(pending.size() - 1, modelOvf, 1'b1));
        bus_addr = '0;
        checkFrame(pending.pop_front(), 11);
        while (pending.size() > 0) checkFrame(pending.pop_front(), 0);
        checkIdle("ovf_end");

        $display("[TB] reset mid-frame");
        applyStimulus(DATA_ADDR, {8'h00, 8'($urandom)});
        @(negedge clk);
        checkOutput("mid_start_bit", {15'b0, tx}, 16'h0000);
        #2 reset = 1'b1;
        #1;
        checkIdle("mid_reset");
        checkOutput("mid_reset_rdata", bus_rdata, 16'h0000);
        pending.delete();
        @(negedge clk);
        reset = 1'b0;
        bus_addr = STATUS_ADDR;
        @(negedge clk);
        checkOutput("status_after_abort", bus_rdata, statusWord(0, 1'b0, 1'b0));
        bus_addr = '0;

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
